prog_sequencer: RTL and testbench

- Run-control and branch-resolution controller for the program counter.
- Parks the PC at the selected program's base address while idle.
- On Start, launches the selected program (one of three) and resolves decoder jump requests against the ALU Zero flag into the PC's BranchAbs/BranchRel/Target inputs.
- Detects Halt, freezes the PC, reports Done and the run's cycle count.

---
 rtl/prog_seq_pkg.sv | 38 +++
 rtl/prog_sequencer_branch_resolve.sv | 43 ++++
 rtl/prog_sequencer.sv | 145 ++++++++++++++
 tb/tb_prog_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_seq_pkg.sv
// Shared types and helpers for the program sequencer.
package prog_seq_pkg;

   // Run-control states of the sequencer.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      HALT = 2'd3
   } seq_state_t;

   // Only three programs exist; selector value 3 is folded onto program 2.
   function automatic logic [1:0] map_sel(input logic [1:0] sel);
      logic [1:0] res;
      if (sel == 2'd3) begin
         res = 2'd2;
      end else begin
         res = sel;
      end
      return res;
   endfunction

   // Start address of the selected program. Bases are passed in so the
   // top-level parameters stay the single source of truth.
   function automatic logic [31:0] base_addr(input logic [1:0]  sel,
                                             input logic [31:0] b0,
                                             input logic [31:0] b1,
                                             input logic [31:0] b2);
      logic [31:0] res;
      case (sel)
         2'd0:    res = b0;
         2'd1:    res = b1;
         default: res = b2;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/prog_sequencer_branch_resolve.sv
// Combinational branch priority for the RUN state:
// Halt (hold PC) > absolute jump > conditional relative jump > fall through.
module branch_resolve
   import prog_seq_pkg::*;
#(
   parameter int unsigned L = 10
) (
   input  logic         halt_i,
   input  logic         jump_abs_i,
   input  logic         jump_eq_i,
   input  logic         jump_ne_i,
   input  logic         zero_i,
   input  logic [L-1:0] pc_i,
   input  logic [L-1:0] jump_target_i,
   output logic         branch_abs_o,
   output logic         branch_rel_o,
   output logic [L-1:0] target_o
);

   logic cond_taken_s;

   // With both JumpEq and JumpNe set exactly one term is true, so it is always taken.
   assign cond_taken_s = (jump_eq_i & zero_i) | (jump_ne_i & ~zero_i);

   // Resolve decoder requests into at most one of absolute / relative load.
   always_comb begin
      branch_abs_o = 1'b0;
      branch_rel_o = 1'b0;
      target_o     = jump_target_i;
      if (halt_i) begin
         branch_abs_o = 1'b1;
         target_o     = pc_i;
      end else if (jump_abs_i) begin
         branch_abs_o = 1'b1;
      end else if (cond_taken_s) begin
         branch_rel_o = 1'b1;
      end else begin
         branch_abs_o = 1'b0;
         branch_rel_o = 1'b0;
      end
   end

endmodule

// File: rtl/prog_sequencer.sv
// Run-control FSM: parks the PC at the program base, launches a program,
// steers branches while running, freezes the PC on Halt and counts RUN cycles.
module prog_sequencer
   import prog_seq_pkg::*;
#(
   parameter int unsigned L     = 10,
   parameter int unsigned CW    = 16,
   parameter int unsigned BASE0 = 32'h000,
   parameter int unsigned BASE1 = 32'h100,
   parameter int unsigned BASE2 = 32'h200
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Start,
   input  logic [1:0]    ProgSel,
   input  logic [L-1:0]  Pc,
   input  logic          Halt,
   input  logic          JumpAbs,
   input  logic          JumpEq,
   input  logic          JumpNe,
   input  logic          ZeroFlag,
   input  logic [L-1:0]  JumpTarget,
   output logic          BranchAbs,
   output logic          BranchRel,
   output logic [L-1:0]  Target,
   output logic          Running,
   output logic          Done,
   output logic [CW-1:0] CycleCount
);

   seq_state_t    state_q;
   logic [1:0]    sel_q;
   logic [CW-1:0] cycle_q;
   logic [CW-1:0] cycle_d;
   logic          running_q;
   logic          done_q;

   logic [1:0]    sel_new_s;
   logic [L-1:0]  base_s;
   logic          rs_abs_s;
   logic          rs_rel_s;
   logic [L-1:0]  rs_tgt_s;

   branch_resolve #(.L(L)) u_branch_resolve (
      .halt_i        (Halt),
      .jump_abs_i    (JumpAbs),
      .jump_eq_i     (JumpEq),
      .jump_ne_i     (JumpNe),
      .zero_i        (ZeroFlag),
      .pc_i          (Pc),
      .jump_target_i (JumpTarget),
      .branch_abs_o  (rs_abs_s),
      .branch_rel_o  (rs_rel_s),
      .target_o      (rs_tgt_s)
   );

   // Program selection, parked base address and saturating counter increment.
   always_comb begin
      sel_new_s = map_sel(ProgSel);
      base_s    = L'(base_addr(sel_q, BASE0, BASE1, BASE2));
      if (&cycle_q) begin
         cycle_d = cycle_q;
      end else begin
         cycle_d = cycle_q + CW'(1'b1);
      end
   end

   // Sequencer FSM with registered status flags and cycle counter.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= IDLE;
         sel_q     <= 2'd0;
         cycle_q   <= {CW{1'b0}};
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (Start) begin
                  sel_q   <= sel_new_s;
                  cycle_q <= {CW{1'b0}};
                  state_q <= LOAD;
               end
            end
            LOAD: begin
               state_q   <= RUN;
               running_q <= 1'b1;
            end
            RUN: begin
               // The halting cycle itself still counts as a RUN cycle.
               cycle_q <= cycle_d;
               if (Halt) begin
                  state_q   <= HALT;
                  running_q <= 1'b0;
                  done_q    <= 1'b1;
               end
            end
            HALT: begin
               if (Start) begin
                  sel_q   <= sel_new_s;
                  cycle_q <= {CW{1'b0}};
                  done_q  <= 1'b0;
                  state_q <= LOAD;
               end
            end
            default: begin
               state_q   <= IDLE;
               running_q <= 1'b0;
               done_q    <= 1'b0;
            end
         endcase
      end
   end

   // PC steering: park at the base outside RUN, freeze in HALT, resolve jumps in RUN.
   always_comb begin
      BranchAbs = 1'b1;
      BranchRel = 1'b0;
      Target    = base_s;
      case (state_q)
         IDLE, LOAD: begin
            BranchAbs = 1'b1;
            Target    = base_s;
         end
         RUN: begin
            BranchAbs = rs_abs_s;
            BranchRel = rs_rel_s;
            Target    = rs_tgt_s;
         end
         HALT: begin
            BranchAbs = 1'b1;
            Target    = Pc;
         end
         default: begin
            BranchAbs = 1'b1;
            Target    = base_s;
         end
      endcase
   end

   assign Running    = running_q;
   assign Done       = done_q;
   assign CycleCount = cycle_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: a PC register as environment, a behavioural model
// checked every cycle, and directed scenarios with literal expectations.
module tb_prog_sequencer;

   localparam int L = 10;

   logic          Clk = 1'b0;
   logic          Reset = 1'b1;
   logic          Start = 1'b0;
   logic [1:0]    ProgSel = 2'd0;
   logic [L-1:0]  pc_r = 10'd0;
   logic          Halt = 1'b0;
   logic          JumpAbs = 1'b0;
   logic          JumpEq = 1'b0;
   logic          JumpNe = 1'b0;
   logic          ZeroFlag = 1'b0;
   logic [L-1:0]  JumpTarget = 10'd0;
   logic          BranchAbs, BranchRel, Running, Done;
   logic [L-1:0]  Target;
   logic [15:0]   CycleCount;
   logic          d4_abs, d4_rel, d4_running, d4_done;
   logic [L-1:0]  d4_tgt;
   logic [3:0]    d4_count;

   int total = 0;
   int bad   = 0;

   prog_sequencer dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .Pc(pc_r),
      .Halt(Halt), .JumpAbs(JumpAbs), .JumpEq(JumpEq), .JumpNe(JumpNe),
      .ZeroFlag(ZeroFlag), .JumpTarget(JumpTarget), .BranchAbs(BranchAbs),
      .BranchRel(BranchRel), .Target(Target), .Running(Running), .Done(Done),
      .CycleCount(CycleCount)
   );

   prog_sequencer #(.CW(4)) dut4 (
      .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .Pc(pc_r),
      .Halt(Halt), .JumpAbs(JumpAbs), .JumpEq(JumpEq), .JumpNe(JumpNe),
      .ZeroFlag(ZeroFlag), .JumpTarget(JumpTarget), .BranchAbs(d4_abs),
      .BranchRel(d4_rel), .Target(d4_tgt), .Running(d4_running), .Done(d4_done),
      .CycleCount(d4_count)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Program counter the sequencer drives: load, add-relative, or increment.
   always @(posedge Clk) begin
      if (Reset)          pc_r <= 10'd0;
      else if (BranchAbs) pc_r <= Target;
      else if (BranchRel) pc_r <= pc_r + Target;
      else                pc_r <= pc_r + 10'd1;
   end

   // Behavioural model: phase 0 idle, 1 load, 2 run, 3 halted.
   int m_valid = 0;
   int m_phase = 0;
   int m_sel   = 0;
   int m_cnt   = 0;
   int base_tab [3] = '{0, 256, 512};

   always @(posedge Clk) begin
      if (Reset) begin
         m_valid <= 1; m_phase <= 0; m_sel <= 0; m_cnt <= 0;
      end else if ((m_phase == 0 || m_phase == 3) && Start) begin
         m_sel   <= (int'(ProgSel) == 3) ? 2 : int'(ProgSel);
         m_cnt   <= 0;
         m_phase <= 1;
      end else if (m_phase == 1) begin
         m_phase <= 2;
      end else if (m_phase == 2) begin
         m_cnt <= (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
         if (Halt) m_phase <= 3;
      end
   end

   typedef struct { int abs_v; int rel_v; int tgt_v; int tgt_known; } exp_t;

   function automatic exp_t expect_outputs();
      exp_t e;
      e.abs_v = 1; e.rel_v = 0; e.tgt_known = 1;
      e.tgt_v = base_tab[m_sel];
      if (m_phase == 3) begin
         e.tgt_v = int'(pc_r);
      end else if (m_phase == 2) begin
         if (Halt) begin
            e.tgt_v = int'(pc_r);
         end else if (JumpAbs) begin
            e.tgt_v = int'(JumpTarget);
         end else if ((JumpEq && ZeroFlag) || (JumpNe && !ZeroFlag)) begin
            e.abs_v = 0; e.rel_v = 1; e.tgt_v = int'(JumpTarget);
         end else begin
            e.abs_v = 0; e.tgt_known = 0;
         end
      end
      return e;
   endfunction

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge Clk) begin
      if (m_valid != 0) begin
         exp_t e;
         e = expect_outputs();
         chk("m_abs", int'(BranchAbs), e.abs_v);
         chk("m_rel", int'(BranchRel), e.rel_v);
         if (e.tgt_known != 0) chk("m_target", int'(Target), e.tgt_v);
         chk("m_running", int'(Running), (m_phase == 2) ? 1 : 0);
         chk("m_done", int'(Done), (m_phase == 3) ? 1 : 0);
         chk("m_count", int'(CycleCount), m_cnt);
         chk("m4_count", int'(d4_count), (m_cnt > 15) ? 15 : m_cnt);
         chk("m4_abs", int'(d4_abs), e.abs_v);
         chk("m4_running", int'(d4_running), (m_phase == 2) ? 1 : 0);
      end
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      int loads;
      // Reset and idle.
      step(); step();
      Reset = 1'b0;
      repeat (3) step();
      chk("idle_abs", int'(BranchAbs), 1);
      chk("idle_target", int'(Target), 0);
      chk("idle_running", int'(Running), 0);
      chk("idle_done", int'(Done), 0);
      chk("idle_count", int'(CycleCount), 0);

      // Program 1 straight-line run halting at 0x104.
      Start = 1'b1; ProgSel = 2'd1;
      step();
      Start = 1'b0; #1;
      chk("load_target", int'(Target), 32'h100);
      chk("load_running", int'(Running), 0);
      step();
      chk("run1_running", int'(Running), 1);
      chk("run1_pc", int'(pc_r), 32'h100);
      repeat (4) step();
      chk("pre_halt_pc", int'(pc_r), 32'h104);
      Halt = 1'b1;
      step();
      Halt = 1'b0; #1;
      chk("halt_done", int'(Done), 1);
      chk("halt_count", int'(CycleCount), 5);
      chk("halt_target", int'(Target), 32'h104);
      step();
      chk("halt_pc_frozen", int'(pc_r), 32'h104);

      // Program 0: branch resolution around Pc=0x010.
      Start = 1'b1; ProgSel = 2'd0;
      step();
      Start = 1'b0;
      step();
      JumpAbs = 1'b1; JumpTarget = 10'h010;
      step();
      JumpAbs = 1'b0; JumpEq = 1'b1; ZeroFlag = 1'b1; JumpTarget = 10'h3FE; #1;
      chk("eq_taken_rel", int'(BranchRel), 1);
      chk("eq_taken_abs", int'(BranchAbs), 0);
      step();
      chk("eq_taken_pc", int'(pc_r), 32'h00E);
      JumpEq = 1'b0; JumpAbs = 1'b1; JumpTarget = 10'h010;
      step();
      JumpAbs = 1'b0; JumpEq = 1'b1; ZeroFlag = 1'b0; JumpTarget = 10'h3FE; #1;
      chk("eq_not_taken_rel", int'(BranchRel), 0);
      chk("eq_not_taken_abs", int'(BranchAbs), 0);
      step();
      chk("eq_not_taken_pc", int'(pc_r), 32'h011);
      JumpEq = 1'b0; JumpNe = 1'b1; ZeroFlag = 1'b0; #1;
      chk("ne_taken_rel", int'(BranchRel), 1);
      step();
      chk("ne_taken_pc", int'(pc_r), 32'h00F);
      JumpEq = 1'b1; JumpNe = 1'b1; ZeroFlag = 1'b1; #1;
      chk("both_taken_rel", int'(BranchRel), 1);
      step();
      chk("both_taken_pc", int'(pc_r), 32'h00D);
      JumpEq = 1'b0; JumpNe = 1'b0; ZeroFlag = 1'b0;
      Halt = 1'b1; JumpAbs = 1'b1; JumpTarget = 10'h050; #1;
      chk("halt_wins_abs", int'(BranchAbs), 1);
      chk("halt_wins_rel", int'(BranchRel), 0);
      chk("halt_wins_target", int'(Target), 32'h00D);
      step();
      Halt = 1'b0; JumpAbs = 1'b0; #1;
      chk("halt_wins_done", int'(Done), 1);
      chk("halt_wins_pc", int'(pc_r), 32'h00D);

      // Reset in the middle of a run.
      Start = 1'b1; ProgSel = 2'd2;
      step();
      Start = 1'b0;
      step();
      repeat (7) step();
      chk("midrun_count", int'(CycleCount), 7);
      Reset = 1'b1;
      step();
      Reset = 1'b0; #1;
      chk("post_reset_running", int'(Running), 0);
      chk("post_reset_count", int'(CycleCount), 0);
      chk("post_reset_target", int'(Target), 0);
      Start = 1'b1; ProgSel = 2'd3;
      step();
      Start = 1'b0; #1;
      chk("sel3_target", int'(Target), 32'h200);

      // Long run: narrow counter saturates.
      step();
      repeat (20) step();
      chk("sat_count4", int'(d4_count), 15);
      chk("wide_count", int'(CycleCount), 20);
      Halt = 1'b1;
      step();
      Halt = 1'b0; #1;
      chk("sat_done", int'(Done), 1);

      // Start held for five cycles from HALT launches once.
      loads = 0;
      Start = 1'b1; ProgSel = 2'd1;
      repeat (5) begin
         step();
         if (!Running && !Done) loads++;
      end
      Start = 1'b0; #1;
      chk("single_launch", loads, 1);
      chk("held_start_running", int'(Running), 1);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
